// File: rtl/code_converter_seq.sv
// Sequential code converter: bin->Gray, Gray->bin (bit-serial), excess-3 and negate, with valid/ready handshakes.
// Optional out_parity port is enabled by defining CODE_CONV_PARITY_EN.
module code_converter_seq #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_carry,
  output logic [7:0]       count
`ifdef CODE_CONV_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] MODE_B2G = 2'b00;
  localparam logic [1:0] MODE_G2B = 2'b01;
  localparam logic [1:0] MODE_XS3 = 2'b10;
  localparam logic [1:0] MODE_NEG = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] gray_r;
  logic [1:0]       mode_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic [7:0]       count_r;

  logic [WIDTH-1:0] direct_data;
  logic             direct_carry;
  logic [WIDTH:0]   sum;

  // Single-edge conversions for every mode except Gray->bin.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    direct_data  = '0;
    direct_carry = 1'b0;
    sum          = '0;
    unique case (in_mode)
      MODE_B2G: direct_data = in_data ^ (in_data >> 1);
      MODE_XS3: begin
        sum          = {1'b0, in_data} + (WIDTH+1)'(3);
        direct_data  = sum[WIDTH-1:0];
        direct_carry = sum[WIDTH];
      end
      MODE_NEG: begin
        sum          = {1'b0, ~in_data} + (WIDTH+1)'(1);
        direct_data  = sum[WIDTH-1:0];
        direct_carry = sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state   <= IDLE;
      data_r  <= '0;
      mode_r  <= MODE_B2G;
      carry_r <= 1'b0;
      idx     <= '0;
      count_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mode_r <= in_mode;
            if (in_mode == MODE_G2B) begin
              data_r  <= {in_data[WIDTH-1], {(WIDTH-1){1'b0}}};
              carry_r <= 1'b0;
              idx     <= IW'(WIDTH-2);
              state   <= CONV;
            end else begin
              data_r  <= direct_data;
              carry_r <= direct_carry;
              state   <= DONE;
            end
          end
        end
        CONV: begin
          // Resolve one binary bit per edge, MSB towards LSB.
          data_r[idx] <= data_r[idx + IW'(1)] ^ gray_r[idx];
          if (idx == '0) state <= DONE;
          else           idx   <= idx - IW'(1);
        end
        DONE: begin
          if (out_ready) begin
            count_r <= count_r + 8'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: gray_r is a pure datapath register that is always loaded before CONV reads it, so it needs no reset.
  always_ff @(posedge Clock) begin
    if (state == IDLE && in_valid) gray_r <= in_data;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_r;
  assign out_mode  = mode_r;
  assign out_carry = carry_r;
  assign count     = count_r;

`ifdef CODE_CONV_PARITY_EN
  assign out_parity = ^data_r;
`endif

endmodule

// File: tb/tb_code_converter_seq.sv
// Randomized self-checking bench for code_converter_seq (WIDTH=4) against a behavioural reference model.
module tb_code_converter_seq;

  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_mode;
  logic         out_carry;
  logic [7:0]   count;
`ifdef CODE_CONV_PARITY_EN
  logic         out_parity;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  code_converter_seq #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_carry (out_carry),
    .count     (count)
`ifdef CODE_CONV_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 Clock = ~Clock;

  // Reference model: arithmetic straight from the conversion rules.
  task automatic model(input logic [W-1:0] d, input logic [1:0] m,
                       output logic [W-1:0] r, output logic c);
    int s;
    r = '0;
    c = 1'b0;
    case (m)
      2'b00: r = d ^ (d >> 1);
      2'b01: for (int i = 0; i < W; i++) r[i] = ^(d >> i);
      2'b10: begin s = int'(d) + 3; r = W'(s % (1 << W)); c = (s >= (1 << W)); end
      default: begin s = ((1 << W) - int'(d)) % (1 << W); r = W'(s); c = (d == 0); end
    endcase
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One full transaction; called just after a rising edge with the DUT idle.
  task automatic run_txn(input logic [W-1:0] d, input logic [1:0] m, input int hold);
    logic [W-1:0] er;
    logic         ec;
    int           lat;
    int           exp_lat;
    model(d, m, er, ec);
    exp_lat = (m == 2'b01) ? W : 1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL idle_in_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_mode = m; out_ready = 1'b0;
    tick();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL busy_in_ready: got %b expected 0", in_ready);
      end
      in_valid = 1'($urandom); in_data = W'($urandom); in_mode = 2'($urandom);
      out_ready = 1'($urandom);
      tick();
      lat++;
    end
    out_ready = 1'b0;
    checks++;
    if (lat !== exp_lat) begin
      failures++; $display("FAIL latency mode=%b d=%h: got %0d expected %0d", m, d, lat, exp_lat);
    end
    repeat (hold + 1) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== er || out_mode !== m
          || out_carry !== ec) begin
        failures++;
        $display("FAIL result mode=%b d=%h: got v=%b r=%b data=%h mode=%b carry=%b expected v=1 r=0 data=%h mode=%b carry=%b",
                 m, d, out_valid, in_ready, out_data, out_mode, out_carry, er, m, ec);
      end
`ifdef CODE_CONV_PARITY_EN
      checks++;
      if (out_parity !== ^er) begin
        failures++; $display("FAIL parity d=%h: got %b expected %b", d, out_parity, ^er);
      end
`endif
      in_valid = 1'b1; in_data = W'($urandom); in_mode = 2'b00;
      tick();
    end
    // Release with in_valid still high: must not be accepted in the same cycle.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_count = (exp_count + 1) % 256;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 8'(exp_count)) begin
      failures++;
      $display("FAIL release: got v=%b r=%b count=%0d expected v=0 r=1 count=%0d",
               out_valid, in_ready, count, exp_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_count = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_mode !== 2'b00
        || out_carry !== 1'b0 || count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got r=%b v=%b data=%h mode=%b carry=%b count=%0d expected r=1 v=0 data=0 mode=00 carry=0 count=0",
               in_ready, out_valid, out_data, out_mode, out_carry, count);
    end
`ifdef CODE_CONV_PARITY_EN
    checks++;
    if (out_parity !== 1'b0) begin
      failures++; $display("FAIL reset_parity: got %b expected 0", out_parity);
    end
`endif
  endtask

  task automatic test_directed();
    run_txn(4'b1011, 2'b00, 0);
    run_txn(4'b1110, 2'b01, 0);
    run_txn(4'b1101, 2'b10, 0);
    run_txn(4'b0101, 2'b10, 1);
    run_txn(4'b0000, 2'b11, 0);
    run_txn(4'b0101, 2'b11, 5);
  endtask

  task automatic test_random();
    repeat (60) run_txn(W'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
  endtask

  task automatic test_reset_precedence();
    // Reset beats an accept in IDLE.
    in_valid = 1'b1; in_data = 4'b1011; in_mode = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    exp_count = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 8'd0) begin
      failures++;
      $display("FAIL reset_vs_accept: got v=%b r=%b count=%0d expected v=0 r=1 count=0",
               out_valid, in_ready, count);
    end
    // Reset beats an output handshake in DONE.
    run_txn(4'b0011, 2'b10, 0);
    in_valid = 1'b1; in_data = 4'b0110; in_mode = 2'b11;
    tick();
    in_valid = 1'b0; reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    exp_count = 0;
    checks++;
    if (out_valid !== 1'b0 || count !== 8'd0 || out_data !== '0 || out_carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_done: got v=%b count=%0d data=%h carry=%b expected v=0 count=0 data=0 carry=0",
               out_valid, count, out_data, out_carry);
    end
  endtask

  task automatic test_reset_mid_conv();
    run_txn(4'b1001, 2'b00, 0);
    in_valid = 1'b1; in_data = 4'b1110; in_mode = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 8'd0 || out_data !== '0
        || out_mode !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_conv: got r=%b v=%b count=%0d data=%h mode=%b expected r=1 v=0 count=0 data=0 mode=00",
               in_ready, out_valid, count, out_data, out_mode);
    end
    repeat (W + 2) begin
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 8'd0) begin
        failures++;
        $display("FAIL aborted_output: got v=%b count=%0d expected v=0 count=0", out_valid, count);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) begin
      run_txn(W'($urandom), 2'($urandom), 0);
      if (i == 254) begin
        checks++;
        if (count !== 8'd255) begin
          failures++; $display("FAIL count_255: got %0d expected 255", count);
        end
      end
    end
    checks++;
    if (count !== 8'd0) begin
      failures++; $display("FAIL count_wrap: got %0d expected 0", count);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_precedence();
    test_reset_mid_conv();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_converter_seq.md
CODE_CONVERTER_SEQ -- requirements
Module: code_converter_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning data width in bits; legal range 2..16.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the source offers a request.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the operand.
REQ-007 The block SHALL have port in_mode, input, 2 bits: 00 bin->Gray, 01 Gray->bin, 10 excess-3 (add 3), 11 two's-complement negate.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a result is held.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the sink takes the result.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the result.
REQ-011 The block SHALL have port out_mode, output, 2 bits: the mode of the held result.
REQ-012 The block SHALL have port out_carry, output, 1 bit: carry-out for modes 10/11, 0 otherwise.
REQ-013 The block SHALL have port count, output, 8 bits: number of completed output handshakes.

Function
REQ-014 The FSM SHALL have states IDLE, CONV and DONE; in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in DONE.
REQ-015 Input accept SHALL occur on a rising edge with in_valid=1 in IDLE; in_data and in_mode SHALL be captured at that edge.
REQ-016 On accept with mode 00, 10 or 11, the FSM SHALL go IDLE->DONE, with the result valid one edge after accept.
REQ-017 On accept with mode 01, the FSM SHALL go IDLE->CONV, set the result MSB to g[W-1], then resolve one bit per edge, MSB to LSB, as b[i]=b[i+1]^g[i].
REQ-018 The FSM SHALL leave CONV for DONE after exactly WIDTH-1 edges in CONV, so out_valid rises WIDTH edges after accept.
REQ-019 Mode 00 SHALL give out_data = d ^ (d>>1).
REQ-020 Mode 10 SHALL give out_data = (d+3) mod 2^WIDTH, with out_carry = 1 iff d+3 >= 2^WIDTH.
REQ-021 Mode 11 SHALL give out_data = (~d+1) mod 2^WIDTH, with out_carry = 1 iff d==0.
REQ-022 In DONE, out_data, out_mode and out_carry SHALL stay stable until an edge with out_ready=1.
REQ-023 On that out_ready edge, the FSM SHALL return to IDLE and count SHALL increment; no new accept SHALL occur in that same cycle.
REQ-024 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-025 count SHALL wrap from 255 to 0.
REQ-026 Illegal WIDTH values are not supported; behaviour outside 2..16 is undefined.

Reset
REQ-027 reset=1 at a rising edge SHALL force: state IDLE, in_ready=1, out_valid=0, out_data=0, out_mode=00, out_carry=0, count=0.
REQ-028 Reset SHALL take precedence over any handshake in the same cycle.
REQ-029 Reset in CONV or DONE SHALL abort the operation, produce no output handshake and leave count unchanged from 0.

Configuration
REQ-030 With macro CODE_CONV_PARITY_EN defined, an output port out_parity (1 bit) SHALL exist, equal to the XOR of all out_data bits, 0 at reset, and stable in DONE like out_data.
REQ-031 Without CODE_CONV_PARITY_EN, out_parity SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-032 Scenario: mode 00, d=1011, out_ready=1 -> out_valid one edge after accept, out_data=1110, out_carry=0, count=1.
REQ-033 Scenario: mode 01, d=1110 -> in_ready=0 and out_valid=0 for 3 edges, then out_data=1011 on the 4th edge after accept.
REQ-034 Scenario: mode 10, d=1101 -> out_data=0000, out_carry=1; mode 10, d=0101 -> out_data=1000, out_carry=0.
REQ-035 Scenario: mode 11, d=0000 -> out_data=0000, out_carry=1; mode 11, d=0101 -> out_data=1011, out_carry=0; hold out_ready=0 for 5 cycles -> outputs stable, in_valid ignored.
REQ-036 Scenario: assert reset mid-CONV (mode 01) -> next edge: IDLE, out_valid=0, count=0; then 256 back-to-back transactions -> count wraps to 0.
REQ-037 Scenario: with CODE_CONV_PARITY_EN defined, mode 00, d=1011 -> out_parity=1.
